tcdm_mem_responder: RTL and testbench



---
 rtl/tcdm_resp_pkg.sv | 12 +
 rtl/tcdm_mem_responder.sv | 126 ++++++++++++
 tb/tb_tcdm_mem_responder.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tcdm_resp_pkg.sv
// Shared types and constants for the TCDM slave-side memory responder.
package tcdm_resp_pkg;

  typedef enum logic {
    IDLE,
    WAIT
  } state_e;

  localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;
  localparam int          WS_WIDTH  = 4;

endpackage

// File: rtl/tcdm_mem_responder.sv
// TCDM request/grant/r_valid slave: optional wait states before grant, maps
// in-range accesses onto an external 1-cycle SRAM, one response per grant.
module tcdm_mem_responder
  import tcdm_resp_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  localparam int                   BE_WIDTH    = DATA_WIDTH / 8,
  parameter int                    MEM_WORDS   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h1C00_0000,
  parameter int                    WAIT_STATES = 0,
  localparam int                   MEM_AW      = $clog2(MEM_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] add_i,
  input  logic                  wen_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [BE_WIDTH-1:0]   be_i,
  output logic                  gnt_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_rdata_o,
  output logic                  r_opc_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [BE_WIDTH-1:0]   mem_be_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]           err_cnt_o
);

  localparam int OFF_BITS = $clog2(BE_WIDTH);
  localparam bit HAS_WAIT = (WAIT_STATES > 0);
  localparam logic [WS_WIDTH-1:0] WAIT_LOAD =
    WS_WIDTH'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);
  // One extra bit so the end of the window cannot wrap at the top of memory.
  localparam logic [ADDR_WIDTH:0] END_ADDR =
    {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(MEM_WORDS * BE_WIDTH);

  state_e              state_q;
  logic [WS_WIDTH-1:0] wait_cnt_q;
  logic                in_range;
  logic                valid_q;
  logic                err_q;
  logic                rd_q;
  logic [15:0]         err_cnt_q;

  assign in_range = (add_i >= BASE_ADDR) && ({1'b0, add_i} < END_ADDR);

  always_comb begin
    gnt_o = 1'b0;
    case (state_q)
      IDLE:    gnt_o = req_i & ~HAS_WAIT;
      WAIT:    gnt_o = req_i & (wait_cnt_q == '0);
      default: gnt_o = 1'b0;
    endcase
  end

  // A dropped request while waiting is a protocol violation: abandon it silently.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_i && HAS_WAIT) begin
            state_q    <= WAIT;
            wait_cnt_q <= WAIT_LOAD;
          end
        end
        WAIT: begin
          if (!req_i || (wait_cnt_q == '0)) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
          end else begin
            wait_cnt_q <= wait_cnt_q - 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          wait_cnt_q <= '0;
        end
      endcase
    end
  end

  assign mem_req_o   = gnt_o & in_range;
  assign mem_we_o    = ~wen_i;
  assign mem_addr_o  = MEM_AW'((add_i - BASE_ADDR) >> OFF_BITS);
  assign mem_wdata_o = wdata_i;
  assign mem_be_o    = be_i;

  // Response flags are rewritten every cycle so they read as zero between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      rd_q      <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      valid_q <= gnt_o;
      err_q   <= gnt_o & ~in_range;
      rd_q    <= gnt_o & wen_i;
      if (gnt_o && !in_range && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign r_valid_o = valid_q;
  assign r_opc_o   = err_q;
  assign err_cnt_o = err_cnt_q;

  always_comb begin
    r_rdata_o = '0;
    if (err_q) begin
      r_rdata_o = DATA_WIDTH'(ERR_RDATA);
    end else if (rd_q) begin
      r_rdata_o = mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_tcdm_mem_responder.sv
// Bench: two responders (0 and 3 wait states) with behavioural SRAMs,
// checked against a word-array reference model of memory contents.
module tb_tcdm_mem_responder;

  localparam logic [31:0] BASE      = 32'h1C00_0000;
  localparam int          WORDS     = 1024;
  localparam logic [31:0] MEM_BYTES = WORDS * 4;
  localparam logic [31:0] ERR_DATA  = 32'hBADA_CCE5;

  logic clk = 1'b0;
  logic rst;

  logic        req0, wen0, gnt0, valid0, opc0, mreq0, mwe0;
  logic [31:0] add0, wdata0, rdata0, mwdata0, mrdata0;
  logic [3:0]  be0, mbe0;
  logic [9:0]  maddr0;
  logic [15:0] errcnt0;

  logic        req1, wen1, gnt1, valid1, opc1, mreq1, mwe1;
  logic [31:0] add1, wdata1, rdata1, mwdata1, mrdata1;
  logic [3:0]  be1, mbe1;
  logic [9:0]  maddr1;
  logic [15:0] errcnt1;

  bit [31:0] sram0 [WORDS];
  bit [31:0] sram1 [WORDS];
  bit [31:0] ref0  [WORDS];
  bit [31:0] ref1  [WORDS];

  int passed = 0;
  int total  = 0;
  int exp_err0 = 0;

  always #5 clk = ~clk;

  tcdm_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .add_i(add0), .wen_i(wen0),
    .wdata_i(wdata0), .be_i(be0), .gnt_o(gnt0), .r_valid_o(valid0),
    .r_rdata_o(rdata0), .r_opc_o(opc0), .mem_req_o(mreq0), .mem_we_o(mwe0),
    .mem_addr_o(maddr0), .mem_wdata_o(mwdata0), .mem_be_o(mbe0),
    .mem_rdata_i(mrdata0), .err_cnt_o(errcnt0)
  );

  tcdm_mem_responder #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS), .WAIT_STATES(3)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .add_i(add1), .wen_i(wen1),
    .wdata_i(wdata1), .be_i(be1), .gnt_o(gnt1), .r_valid_o(valid1),
    .r_rdata_o(rdata1), .r_opc_o(opc1), .mem_req_o(mreq1), .mem_we_o(mwe1),
    .mem_addr_o(maddr1), .mem_wdata_o(mwdata1), .mem_be_o(mbe1),
    .mem_rdata_i(mrdata1), .err_cnt_o(errcnt1)
  );

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port SRAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (mreq0) begin
      if (mwe0) sram0[maddr0] <= merge(sram0[maddr0], mwdata0, mbe0);
      else      mrdata0 <= sram0[maddr0];
    end
    if (mreq1) begin
      if (mwe1) sram1[maddr1] <= merge(sram1[maddr1], mwdata1, mbe1);
      else      mrdata1 <= sram1[maddr1];
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic r, input logic [31:0] a, input logic w,
                        input logic [31:0] d, input logic [3:0] b);
    req0 = r; add0 = a; wen0 = w; wdata0 = d; be0 = b;
  endtask

  task automatic test_reset;
    #2;
    total++; if (gnt0 !== 1'b0) $display("[TB] FAIL reset gnt0 got %b want 0", gnt0); else passed++;
    total++; if (valid0 !== 1'b0) $display("[TB] FAIL reset valid0 got %b want 0", valid0); else passed++;
    total++; if (opc0 !== 1'b0) $display("[TB] FAIL reset opc0 got %b want 0", opc0); else passed++;
    total++; if (rdata0 !== 32'h0) $display("[TB] FAIL reset rdata0 got %h want 0", rdata0); else passed++;
    total++; if (mreq0 !== 1'b0) $display("[TB] FAIL reset mreq0 got %b want 0", mreq0); else passed++;
    total++; if (errcnt0 !== 16'h0) $display("[TB] FAIL reset errcnt0 got %h want 0", errcnt0); else passed++;
    total++; if (valid1 !== 1'b0) $display("[TB] FAIL reset valid1 got %b want 0", valid1); else passed++;
    total++; if (errcnt1 !== 16'h0) $display("[TB] FAIL reset errcnt1 got %h want 0", errcnt1); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_write_read;
    step; drive0(1'b1, BASE + 32'd8, 1'b0, 32'hDEADBEEF, 4'hF);
    ref0[2] = merge(ref0[2], 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) $display("[TB] FAIL wr_gnt got %b want 1", gnt0); else passed++;
    total++; if (mreq0 !== 1'b1 || mwe0 !== 1'b1 || maddr0 !== 10'd2)
      $display("[TB] FAIL wr_mem got req=%b we=%b addr=%0d want 1 1 2", mreq0, mwe0, maddr0); else passed++;
    step; drive0(1'b1, BASE + 32'd8, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rd_gnt got %b want 1", gnt0); else passed++;
    total++; if (valid0 !== 1'b1 || opc0 !== 1'b0 || rdata0 !== 32'h0)
      $display("[TB] FAIL wr_resp got v=%b opc=%b d=%h want 1 0 0", valid0, opc0, rdata0); else passed++;
    step; drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (valid0 !== 1'b1 || opc0 !== 1'b0 || rdata0 !== 32'hDEADBEEF)
      $display("[TB] FAIL rd_resp got v=%b opc=%b d=%h want 1 0 deadbeef", valid0, opc0, rdata0); else passed++;
    step;
    @(negedge clk);
    total++; if (valid0 !== 1'b0) $display("[TB] FAIL resp_once got %b want 0", valid0); else passed++;
  endtask

  task automatic test_byte_enables;
    step; drive0(1'b1, BASE + 32'd16, 1'b0, 32'hFFFFFFFF, 4'hF);
    ref0[4] = merge(ref0[4], 32'hFFFFFFFF, 4'hF);
    step; drive0(1'b1, BASE + 32'd16, 1'b0, 32'h11223344, 4'b0101);
    ref0[4] = merge(ref0[4], 32'h11223344, 4'b0101);
    step; drive0(1'b1, BASE + 32'd19, 1'b1, 32'h0, 4'hF);
    step; drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (valid0 !== 1'b1 || rdata0 !== 32'hFF22FF44)
      $display("[TB] FAIL byte_en got v=%b d=%h want 1 ff22ff44", valid0, rdata0); else passed++;
  endtask

  task automatic test_error;
    step; drive0(1'b1, BASE - 32'd4, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1 || mreq0 !== 1'b0)
      $display("[TB] FAIL err_lo got gnt=%b mreq=%b want 1 0", gnt0, mreq0); else passed++;
    step; drive0(1'b1, BASE + MEM_BYTES, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1 || mreq0 !== 1'b0)
      $display("[TB] FAIL err_hi got gnt=%b mreq=%b want 1 0", gnt0, mreq0); else passed++;
    total++; if (valid0 !== 1'b1 || opc0 !== 1'b1 || rdata0 !== ERR_DATA)
      $display("[TB] FAIL err_resp1 got v=%b opc=%b d=%h want 1 1 badacce5", valid0, opc0, rdata0); else passed++;
    step; drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (valid0 !== 1'b1 || opc0 !== 1'b1 || rdata0 !== ERR_DATA)
      $display("[TB] FAIL err_resp2 got v=%b opc=%b d=%h want 1 1 badacce5", valid0, opc0, rdata0); else passed++;
    total++; if (errcnt0 !== 16'd2) $display("[TB] FAIL err_cnt got %0d want 2", errcnt0); else passed++;
    exp_err0 = 2;
  endtask

  task automatic test_stream;
    logic [31:0] expq [$];
    int idx;
    for (int i = 0; i <= 8; i++) begin
      step;
      if (i < 8) begin
        idx = $urandom_range(0, WORDS - 1);
        expq.push_back(ref0[idx]);
        drive0(1'b1, BASE + 32'(idx * 4), 1'b1, 32'h0, 4'hF);
      end else begin
        drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      end
      @(negedge clk);
      if (i < 8) begin
        total++; if (gnt0 !== 1'b1) $display("[TB] FAIL stream_gnt[%0d] got %b want 1", i, gnt0); else passed++;
      end
      if (i > 0) begin
        total++; if (valid0 !== 1'b1 || rdata0 !== expq[0])
          $display("[TB] FAIL stream_resp[%0d] got v=%b d=%h want 1 %h", i - 1, valid0, rdata0, expq[0]);
        else passed++;
        void'(expq.pop_front());
      end
    end
  endtask

  task automatic test_random;
    logic        pv, popc, active, is_err, rd;
    logic [31:0] pdata, edata, a, d;
    logic [3:0]  b;
    int          idx;
    pv = 1'b0; popc = 1'b0; pdata = '0;
    for (int i = 0; i <= 40; i++) begin
      step;
      active = (i < 40) && ($urandom_range(0, 3) != 0);
      is_err = ($urandom_range(0, 7) == 0);
      rd     = 1'($urandom_range(0, 1));
      d      = $urandom;
      b      = 4'($urandom_range(0, 15));
      idx    = $urandom_range(0, WORDS - 1);
      if (is_err) a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 16))
                                           : BASE + MEM_BYTES + 32'(4 * $urandom_range(0, 15));
      else        a = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      edata = is_err ? ERR_DATA : (rd ? ref0[idx] : 32'h0);
      if (active && !is_err && !rd) ref0[idx] = merge(ref0[idx], d, b);
      if (active && is_err) exp_err0++;
      drive0(active, a, rd, d, b);
      @(negedge clk);
      total++; if (gnt0 !== active || mreq0 !== (active && !is_err))
        $display("[TB] FAIL rand_gnt[%0d] got gnt=%b mreq=%b want %b %b", i, gnt0, mreq0, active, active && !is_err);
      else passed++;
      if (i > 0) begin
        total++; if (valid0 !== pv) $display("[TB] FAIL rand_valid[%0d] got %b want %b", i, valid0, pv); else passed++;
        if (pv) begin
          total++; if (opc0 !== popc || rdata0 !== pdata)
            $display("[TB] FAIL rand_resp[%0d] got opc=%b d=%h want %b %h", i, opc0, rdata0, popc, pdata);
          else passed++;
        end
      end
      pv = active; popc = is_err; pdata = edata;
    end
    total++; if (errcnt0 !== 16'(exp_err0)) $display("[TB] FAIL rand_errcnt got %0d want %0d", errcnt0, exp_err0); else passed++;
  endtask

  task automatic test_wait_states;
    int gnt_cyc = -1;
    int val_cyc = -1;
    logic [31:0] got = '0;
    ref1[7] = 32'hCAFE0007;
    step; req1 = 1'b0; add1 = BASE + 32'd28; wen1 = 1'b0; wdata1 = ref1[7]; be1 = 4'hF;
    req1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt1 && gnt_cyc < 0) gnt_cyc = c;
      step;
      if (gnt_cyc >= 0) req1 = 1'b0;
    end
    step; wen1 = 1'b1; req1 = 1'b1;
    gnt_cyc = -1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt1 && gnt_cyc < 0) gnt_cyc = c;
      if (valid1 && val_cyc < 0) begin val_cyc = c; got = rdata1; end
      step;
      if (gnt_cyc >= 0) req1 = 1'b0;
    end
    total++; if (gnt_cyc !== 3) $display("[TB] FAIL ws_gnt_cycle got %0d want 3", gnt_cyc); else passed++;
    total++; if (val_cyc !== 4) $display("[TB] FAIL ws_valid_cycle got %0d want 4", val_cyc); else passed++;
    total++; if (got !== ref1[7]) $display("[TB] FAIL ws_rdata got %h want %h", got, ref1[7]); else passed++;
  endtask

  task automatic test_abort;
    int gnt_cyc = -1;
    int seen = 0;
    step; add1 = BASE + 32'd40; wen1 = 1'b1; be1 = 4'hF; req1 = 1'b1;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (gnt1 || valid1) seen++;
      step;
      if (c == 1) req1 = 1'b0;
    end
    total++; if (seen !== 0) $display("[TB] FAIL abort_quiet got %0d events want 0", seen); else passed++;
    req1 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt1 && gnt_cyc < 0) gnt_cyc = c;
      step;
      if (gnt_cyc >= 0) req1 = 1'b0;
    end
    total++; if (gnt_cyc !== 3) $display("[TB] FAIL abort_regnt got %0d want 3", gnt_cyc); else passed++;
  endtask

  task automatic test_reset_mid;
    int gnt_cyc = -1;
    step; drive0(1'b1, BASE + 32'd8, 1'b1, 32'h0, 4'hF);
    add1 = BASE + 32'd44; wen1 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) $display("[TB] FAIL rst_pre_gnt got %b want 1", gnt0); else passed++;
    step; drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    total++; if (valid0 !== 1'b1) $display("[TB] FAIL rst_pre_valid got %b want 1", valid0); else passed++;
    rst = 1'b1;
    #1;
    total++; if (valid0 !== 1'b0) $display("[TB] FAIL rst_valid got %b want 0", valid0); else passed++;
    total++; if (errcnt0 !== 16'h0) $display("[TB] FAIL rst_errcnt got %0d want 0", errcnt0); else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (gnt1 && gnt_cyc < 0) gnt_cyc = c;
      step;
      if (gnt_cyc >= 0) req1 = 1'b0;
    end
    total++; if (gnt_cyc !== 3) $display("[TB] FAIL rst_wait_restart got %0d want 3", gnt_cyc); else passed++;
    step; drive0(1'b1, BASE + 32'd8, 1'b1, 32'h0, 4'hF);
    @(negedge clk);
    total++; if (gnt0 !== 1'b1) $display("[TB] FAIL post_rst_gnt got %b want 1", gnt0); else passed++;
    step; drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    @(negedge clk);
    total++; if (valid0 !== 1'b1 || rdata0 !== ref0[2])
      $display("[TB] FAIL post_rst_resp got v=%b d=%h want 1 %h", valid0, rdata0, ref0[2]); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    drive0(1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
    req1 = 1'b0; add1 = '0; wen1 = 1'b1; wdata1 = '0; be1 = '0;
    test_reset;
    test_write_read;
    test_byte_enables;
    test_error;
    test_stream;
    test_random;
    test_wait_states;
    test_abort;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
